// File: rtl/sw_result_collector_pkg.sv
// ============================================================================
//  Module   : sw_result_collector_pkg
//  Purpose  : Shared widths, default FIFO depth and FSM state encodings for
//             the Smith-Waterman result collector.
//             CALC_BIT / MAX_T_NUM_BIT may be predefined by the build;
//             otherwise the defaults below apply.
//             Optional feature macro: SW_RESULT_CHECK_EN (see top module).
//  Revision : 1.0  initial release
// ============================================================================
`ifndef SW_RESULT_COLLECTOR_PKG_SV
`define SW_RESULT_COLLECTOR_PKG_SV

`default_nettype none

`ifndef CALC_BIT
`define CALC_BIT 16
`endif

`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 4
`endif

`ifndef SW_FIFO_DEPTH
`define SW_FIFO_DEPTH 4
`endif

`ifndef SW_ST_IDLE
`define SW_ST_IDLE  2'd0
`define SW_ST_RUN   2'd1
`define SW_ST_DRAIN 2'd2
`define SW_ST_DONE  2'd3
`endif

package sw_result_collector_pkg;

    // Score width, target index width and target count width (one extra bit
    // so a query that scored every possible target can report the full count)
    localparam int c_calc_w         = `CALC_BIT;
    localparam int c_t_w            = `MAX_T_NUM_BIT;
    localparam int c_cnt_w          = `MAX_T_NUM_BIT + 1;
    localparam int c_fifo_depth_def = `SW_FIFO_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE  = `SW_ST_IDLE,
        ST_RUN   = `SW_ST_RUN,
        ST_DRAIN = `SW_ST_DRAIN,
        ST_DONE  = `SW_ST_DONE
    } state_t;

endpackage

`default_nettype wire

`endif

// File: rtl/sw_rec_fifo.sv
// ============================================================================
//  Module   : sw_rec_fifo
//  Purpose  : Small synchronous FIFO for per-query records. Head entry is
//             read directly from storage (no bypass from write side).
//             Full/empty are distinguished by an extra pointer MSB.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign rdata = r_mem[r_rptr[c_aw-1:0]];

    // Pointer update; clear discards everything buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage; zeroed on reset so the head outputs read 0 while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !clr) begin
            r_mem[r_wptr[c_aw-1:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sw_result_collector.sv
// ============================================================================
//  Module   : sw_result_collector
//  Purpose  : Collects per-query best-match results from a SmithWaterman core
//             into a record FIFO, tracks target/query indices and reports
//             run completion, overflow and (optionally) a best-score check.
//             Optional feature macro: SW_RESULT_CHECK_EN -- when defined the
//             module recomputes the per-query best score/index from result_i
//             and flags disagreement on check_err_o; otherwise check_err_o=0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_result_collector
    import sw_result_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = c_fifo_depth_def,
    parameter int Q_IDX_BIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  busy_i,
    input  logic                  valid_i,
    input  logic [c_calc_w-1:0]   result_i,
    input  logic                  change_q_i,
    input  logic [c_t_w-1:0]      match_idx_i,
    input  logic [c_calc_w-1:0]   max_result_i,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [Q_IDX_BIT-1:0]  rec_q_idx_o,
    output logic [c_t_w-1:0]      rec_t_idx_o,
    output logic [c_calc_w-1:0]   rec_score_o,
    output logic [c_cnt_w-1:0]    rec_t_cnt_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  check_err_o
);

    localparam int c_rec_w = Q_IDX_BIT + c_t_w + c_calc_w + c_cnt_w;

    state_t                 r_state;
    logic [c_t_w-1:0]       r_t_idx;
    logic [Q_IDX_BIT-1:0]   r_q_idx;
    logic                   r_seen_busy;
    logic                   r_overflow;
    logic                   r_done;

    logic                   w_clr;
    logic                   w_run_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_cnt_w-1:0]     w_t_cnt;
    logic [c_rec_w-1:0]     w_wdata;
    logic [c_rec_w-1:0]     w_rdata;

    // A new run may only begin from IDLE or DONE
    assign w_clr       = start_i && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_run_valid = valid_i && (r_state == ST_RUN);
    assign w_push      = w_run_valid && change_q_i;
    assign w_pop       = rec_valid_o && rec_ready_i;
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_t_cnt     = {1'b0, r_t_idx} + 1'b1;
    assign w_wdata     = {r_q_idx, match_idx_i, max_result_i, w_t_cnt};

    sw_rec_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rec_valid_o = !w_empty;
    assign {rec_q_idx_o, rec_t_idx_o, rec_score_o, rec_t_cnt_o} = w_rdata;
    assign done_o      = r_done;
    assign overflow_o  = r_overflow;

    // Run-control FSM with target/query counters and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_t_idx     <= '0;
            r_q_idx     <= '0;
            r_seen_busy <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_state     <= ST_RUN;
                        r_t_idx     <= '0;
                        r_q_idx     <= '0;
                        r_seen_busy <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // busy low only ends the run once the core has been seen busy
                    if (busy_i) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_state <= ST_DRAIN;
                    end
                    if (w_run_valid) begin
                        if (change_q_i) begin
                            r_t_idx <= '0;
                            r_q_idx <= r_q_idx + 1'b1;
                            if (w_drop) r_overflow <= 1'b1;
                        end else begin
                            r_t_idx <= r_t_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SW_RESULT_CHECK_EN
    logic [c_calc_w-1:0]    r_run_max;
    logic [c_t_w-1:0]       r_run_idx;
    logic                   r_check_err;
    logic                   w_take;
    logic [c_calc_w-1:0]    w_best_max;
    logic [c_t_w-1:0]       w_best_idx;

    // Strictly greater replaces the running best, so ties keep the earlier index
    always_comb begin
        w_take     = (result_i > r_run_max);
        w_best_max = w_take ? result_i : r_run_max;
        w_best_idx = w_take ? r_t_idx  : r_run_idx;
    end

    // Running best per query, compared against the core's report at query end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_check_err <= 1'b0;
        end else if (w_clr) begin
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_check_err <= 1'b0;
        end else if (w_run_valid) begin
            if (change_q_i) begin
                if (w_best_max != max_result_i || w_best_idx != match_idx_i) begin
                    r_check_err <= 1'b1;
                end
                r_run_max <= '0;
                r_run_idx <= '0;
            end else begin
                r_run_max <= w_best_max;
                r_run_idx <= w_best_idx;
            end
        end
    end

    assign check_err_o = r_check_err;
`else
    logic w_unused_result;

    // result_i only feeds the optional checker
    assign w_unused_result = ^result_i;
    assign check_err_o     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_result_collector.sv
// ============================================================================
//  Module   : tb_sw_result_collector
//  Purpose  : Directed, table-driven bench for sw_result_collector with
//             default parameters (FIFO_DEPTH=4, Q_IDX_BIT=8, MAX_T_NUM_BIT=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sw_result_collector;
    import sw_result_collector_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 start_i;
    logic                 busy_i;
    logic                 valid_i;
    logic [c_calc_w-1:0]  result_i;
    logic                 change_q_i;
    logic [c_t_w-1:0]     match_idx_i;
    logic [c_calc_w-1:0]  max_result_i;
    logic                 rec_valid_o;
    logic                 rec_ready_i;
    logic [7:0]           rec_q_idx_o;
    logic [c_t_w-1:0]     rec_t_idx_o;
    logic [c_calc_w-1:0]  rec_score_o;
    logic [c_cnt_w-1:0]   rec_t_cnt_o;
    logic                 done_o;
    logic                 overflow_o;
    logic                 check_err_o;

    int total;
    int bad;

`ifdef SW_RESULT_CHECK_EN
    localparam bit c_exp_err = 1'b1;
`else
    localparam bit c_exp_err = 1'b0;
`endif

    typedef struct {
        int n;
        int match;
        int max;
        int exp_t;
        int exp_score;
        int exp_cnt;
    } vec_t;

    vec_t tbl[5];

    sw_result_collector #(
        .FIFO_DEPTH (4),
        .Q_IDX_BIT  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .busy_i       (busy_i),
        .valid_i      (valid_i),
        .result_i     (result_i),
        .change_q_i   (change_q_i),
        .match_idx_i  (match_idx_i),
        .max_result_i (max_result_i),
        .rec_valid_o  (rec_valid_o),
        .rec_ready_i  (rec_ready_i),
        .rec_q_idx_o  (rec_q_idx_o),
        .rec_t_idx_o  (rec_t_idx_o),
        .rec_score_o  (rec_score_o),
        .rec_t_cnt_o  (rec_t_cnt_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .check_err_o  (check_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_target(input int res, input bit last, input int match,
                                input int mx, input bit rdy);
        busy_i       = 1'b1;
        valid_i      = 1'b1;
        result_i     = c_calc_w'(res);
        change_q_i   = last;
        match_idx_i  = last ? c_t_w'(match) : '0;
        max_result_i = last ? c_calc_w'(mx) : '0;
        rec_ready_i  = rdy;
        tick();
        valid_i      = 1'b0;
        change_q_i   = 1'b0;
        rec_ready_i  = 1'b0;
    endtask

    // Best target carries mx, all others score 1 (strictly lower)
    task automatic feed_query(input int n, input int match, input int mx, input bit rdy_last);
        for (int k = 0; k < n; k++) begin
            drive_target((k == match) ? mx : 1, (k == n - 1), match, mx, (k == n - 1) && rdy_last);
        end
    endtask

    task automatic pop_check(input string name, input int q, input int t, input int sc, input int cnt);
        chk({name, ".valid"}, rec_valid_o, 1);
        chk({name, ".q"},     rec_q_idx_o, q);
        chk({name, ".t"},     rec_t_idx_o, t);
        chk({name, ".score"}, rec_score_o, sc);
        chk({name, ".cnt"},   rec_t_cnt_o, cnt);
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_o && n < 8) begin
            tick();
            n++;
        end
        chk(name, done_o, 1);
    endtask

    initial begin
        int dcnt;
        total = 0;
        bad   = 0;
        // n, match, max, exp_t, exp_score, exp_cnt (count wraps at 16 targets)
        tbl[0] = '{2,  0,  20,    0,  20,    2};
        tbl[1] = '{16, 15, 7,     15, 7,     16};
        tbl[2] = '{17, 3,  100,   3,  100,   1};
        tbl[3] = '{1,  0,  65535, 0,  65535, 1};
        tbl[4] = '{4,  2,  8,     2,  8,     4};

        rst_n = 1'b1; start_i = 0; busy_i = 0; valid_i = 0; result_i = '0;
        change_q_i = 0; match_idx_i = '0; max_result_i = '0; rec_ready_i = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.rec_valid", rec_valid_o, 0);
        chk("rst.done",      done_o, 0);
        chk("rst.overflow",  overflow_o, 0);
        chk("rst.check_err", check_err_o, 0);
        chk("rst.q",         rec_q_idx_o, 0);
        chk("rst.score",     rec_score_o, 0);
        chk("rst.cnt",       rec_t_cnt_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single query, busy low for two cycles first (must not end the run)
        do_start();
        busy_i = 1'b0;
        tick();
        tick();
        chk("early_idle.done", done_o, 0);
        drive_target(3, 0, 0, 0, 0);
        drive_target(12, 0, 0, 0, 0);
        chk("single.pre_valid", rec_valid_o, 0);
        drive_target(7, 1, 1, 12, 0);
        chk("single.check_err", check_err_o, 0);
        pop_check("single", 0, 1, 12, 3);
        chk("single.empty", rec_valid_o, 0);
        busy_i = 1'b0;
        wait_done("single.done");

        // Table: five queries with consumer stalled; fifth record dropped
        do_start();
        chk("tbl.done_clr", done_o, 0);
        for (int i = 0; i < 5; i++) feed_query(tbl[i].n, tbl[i].match, tbl[i].max, 1'b0);
        chk("tbl.overflow", overflow_o, 1);
        chk("tbl.check_err", check_err_o, 0);
        for (int i = 0; i < 4; i++) begin
            pop_check($sformatf("tbl%0d", i), i, tbl[i].exp_t, tbl[i].exp_score, tbl[i].exp_cnt);
        end
        chk("tbl.empty", rec_valid_o, 0);
        busy_i = 1'b0;
        wait_done("tbl.done");
        chk("tbl.overflow_sticky", overflow_o, 1);

        // Push and pop together while full: no drop
        do_start();
        chk("full.overflow_clr", overflow_o, 0);
        for (int i = 0; i < 4; i++) feed_query(tbl[i].n, tbl[i].match, tbl[i].max, 1'b0);
        feed_query(1, 0, 55, 1'b1);
        chk("full.overflow", overflow_o, 0);
        for (int i = 1; i < 4; i++) begin
            pop_check($sformatf("full%0d", i), i, tbl[i].exp_t, tbl[i].exp_score, tbl[i].exp_cnt);
        end
        pop_check("full4", 4, 0, 55, 1);
        chk("full.empty", rec_valid_o, 0);

        // Busy falls with two records pending, consumer stalled 10 cycles
        feed_query(2, 1, 30, 1'b0);
        feed_query(3, 2, 40, 1'b0);
        busy_i = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_o) dcnt++;
        end
        chk("drain.done_held", dcnt, 0);
        pop_check("drain5", 5, 1, 30, 2);
        chk("drain.done_mid", done_o, 0);
        pop_check("drain6", 6, 2, 40, 3);
        wait_done("drain.done");

        // Best-score checker: index disagrees with recomputed best
        do_start();
        drive_target(5, 0, 0, 0, 1);
        drive_target(9, 0, 0, 0, 1);
        drive_target(9, 1, 2, 9, 1);
        chk("check.err_bad_idx", check_err_o, c_exp_err);
        pop_check("check0", 0, 2, 9, 3);
        busy_i = 1'b0;
        wait_done("check.done");
        do_start();
        drive_target(5, 0, 0, 0, 0);
        drive_target(9, 0, 0, 0, 0);
        drive_target(9, 1, 1, 9, 0);
        chk("check.err_good", check_err_o, 0);
        pop_check("check1", 0, 1, 9, 3);

        // Asynchronous reset mid-run with two buffered records
        feed_query(1, 0, 11, 1'b0);
        feed_query(1, 0, 12, 1'b0);
        chk("rstmid.pre_valid", rec_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.valid", rec_valid_o, 0);
        chk("rstmid.q", rec_q_idx_o, 0);
        chk("rstmid.done", done_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive_target(4, 1, 0, 4, 0);
            if (rec_valid_o) dcnt++;
        end
        chk("rstmid.ignored", dcnt, 0);
        chk("rstmid.done_idle", done_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
